// File: rtl/ps2_pkg.sv
// Shared state encoding and prefix byte values for the PS/2 frame receiver.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_e;

   localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
   localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a glitch filter: the output only moves after
// FILTER_LEN consecutive synchronized samples disagree with it. Idles high.
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clock,
   input  logic reset,
   input  logic raw_in,
   output logic level_out
);

   localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   logic          sync1_q;
   logic          sync2_q;
   logic          level_q;
   logic          level_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw_in;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   // Any sample agreeing with the current level restarts the run.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CW'(FILTER_LEN - 1)) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   assign level_out = level_q;

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver producing one qualified scancode pulse per key event.
// Optional E0/F0 prefix folding into code_ext/code_break is built when PS2_PREFIX_DECODE_EN is defined.
module ps2_frame_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 200_000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ps2_clock,
   input  logic       ps2_data,
   output logic [7:0] code,
   output logic       code_ext,
   output logic       code_break,
   output logic       code_valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic          clk_filt;
   logic          data_filt;
   logic          clk_prev_q;
   logic          fall;

   ps2_state_e    state_q;
   ps2_state_e    state_d;
   logic [7:0]    shift_q;
   logic [7:0]    shift_d;
   logic [2:0]    bit_cnt_q;
   logic [2:0]    bit_cnt_d;
   logic          parity_q;
   logic          parity_d;
   logic [TW-1:0] tout_q;
   logic [TW-1:0] tout_d;
   logic          byte_ok;
   logic          frame_bad;

   logic [7:0]    code_q;
   logic [7:0]    code_d;
   logic          code_valid_q;
   logic          code_valid_d;
   logic          frame_err_q;
   logic          frame_err_d;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
      .clock     (clock),
      .reset     (reset),
      .raw_in    (ps2_clock),
      .level_out (clk_filt)
   );

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
      .clock     (clock),
      .reset     (reset),
      .raw_in    (ps2_data),
      .level_out (data_filt)
   );

   assign fall = clk_prev_q & ~clk_filt;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         clk_prev_q   <= 1'b1;
         shift_q      <= '0;
         bit_cnt_q    <= '0;
         parity_q     <= 1'b0;
         tout_q       <= '0;
         code_q       <= '0;
         code_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         clk_prev_q   <= clk_filt;
         shift_q      <= shift_d;
         bit_cnt_q    <= bit_cnt_d;
         parity_q     <= parity_d;
         tout_q       <= tout_d;
         code_q       <= code_d;
         code_valid_q <= code_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

   // A clock edge takes precedence over an expiring timeout.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      parity_d  = parity_q;
      tout_d    = tout_q;
      byte_ok   = 1'b0;
      frame_bad = 1'b0;

      if (state_q == IDLE || fall) begin
         tout_d = '0;
      end else if (tout_q == TW'(TIMEOUT_CYCLES - 1)) begin
         tout_d    = '0;
         frame_bad = 1'b1;
         state_d   = IDLE;
      end else begin
         tout_d = tout_q + 1'b1;
      end

      if (fall) begin
         case (state_q)
            IDLE: begin
               if (!data_filt) begin
                  state_d   = DATA;
                  bit_cnt_d = '0;
               end else begin
                  frame_bad = 1'b1;
               end
            end
            DATA: begin
               shift_d   = {data_filt, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = PARITY;
               end
            end
            PARITY: begin
               parity_d = data_filt;
               state_d  = STOP;
            end
            default: begin
               if (data_filt && (^{shift_q, parity_q})) begin
                  byte_ok = 1'b1;
               end else begin
                  frame_bad = 1'b1;
               end
               state_d = IDLE;
            end
         endcase
      end
   end

`ifdef PS2_PREFIX_DECODE_EN
   logic ext_pend_q;
   logic ext_pend_d;
   logic brk_pend_q;
   logic brk_pend_d;
   logic code_ext_q;
   logic code_ext_d;
   logic code_break_q;
   logic code_break_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         ext_pend_q   <= 1'b0;
         brk_pend_q   <= 1'b0;
         code_ext_q   <= 1'b0;
         code_break_q <= 1'b0;
      end else begin
         ext_pend_q   <= ext_pend_d;
         brk_pend_q   <= brk_pend_d;
         code_ext_q   <= code_ext_d;
         code_break_q <= code_break_d;
      end
   end
`endif

   always_comb begin
      busy         = (state_q != IDLE);
      code_d       = code_q;
      code_valid_d = 1'b0;
      frame_err_d  = frame_bad;
`ifdef PS2_PREFIX_DECODE_EN
      ext_pend_d   = ext_pend_q;
      brk_pend_d   = brk_pend_q;
      code_ext_d   = code_ext_q;
      code_break_d = code_break_q;
      if (frame_bad) begin
         ext_pend_d = 1'b0;
         brk_pend_d = 1'b0;
      end else if (byte_ok) begin
         if (shift_q == PS2_EXT_PREFIX) begin
            ext_pend_d = 1'b1;
         end else if (shift_q == PS2_BREAK_PREFIX) begin
            brk_pend_d = 1'b1;
         end else begin
            code_d       = shift_q;
            code_ext_d   = ext_pend_q;
            code_break_d = brk_pend_q;
            code_valid_d = 1'b1;
            ext_pend_d   = 1'b0;
            brk_pend_d   = 1'b0;
         end
      end
`else
      if (byte_ok) begin
         code_d       = shift_q;
         code_valid_d = 1'b1;
      end
`endif
   end

   assign code       = code_q;
   assign code_valid = code_valid_q;
   assign frame_err  = frame_err_q;
`ifdef PS2_PREFIX_DECODE_EN
   assign code_ext   = code_ext_q;
   assign code_break = code_break_q;
`else
   assign code_ext   = 1'b0;
   assign code_break = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Bench for ps2_frame_rx: table of frames plus hand-written timeout, glitch and reset sequences.
// Expectations follow PS2_PREFIX_DECODE_EN when it is defined for the build.
module tb_ps2_frame_rx;

   localparam int FL   = 4;
   localparam int TO   = 300;
   localparam int HALF = 20;
`ifdef PS2_PREFIX_DECODE_EN
   localparam bit DEC = 1'b1;
`else
   localparam bit DEC = 1'b0;
`endif

   logic       clock     = 1'b0;
   logic       reset     = 1'b1;
   logic       ps2_clock = 1'b1;
   logic       ps2_data  = 1'b1;
   logic [7:0] code;
   logic       code_ext;
   logic       code_break;
   logic       code_valid;
   logic       frame_err;
   logic       busy;

   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;
   int unsigned fall_cyc = 0;
   int unsigned err_cyc = 0;
   int          err_cnt = 0;
   logic        prev_valid = 1'b0;
   logic        prev_err = 1'b0;

   typedef struct {
      bit         is_err;
      logic [7:0] code;
      bit         ext;
      bit         brk;
   } exp_t;

   typedef enum {K_VALID, K_PREFIX, K_ERR} kind_e;

   typedef struct {
      logic [7:0] data;
      bit         flip_par;
      bit         bad_stop;
      kind_e      kind;
      logic [7:0] code;
      bit         ext;
      bit         brk;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[13];

   ps2_frame_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
      .clock      (clock),
      .reset      (reset),
      .ps2_clock  (ps2_clock),
      .ps2_data   (ps2_data),
      .code       (code),
      .code_ext   (code_ext),
      .code_break (code_break),
      .code_valid (code_valid),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Scoreboard: every output pulse must match the oldest pending expectation.
   always @(negedge clock) begin
      exp_t e;
      if (code_valid || frame_err) begin
         checks++;
         if ((code_valid && frame_err) || (code_valid && prev_valid) || (frame_err && prev_err)) begin
            errors++;
            $display("FAIL pulse_shape got valid=%0b err=%0b prev_valid=%0b prev_err=%0b required single isolated pulse",
                     code_valid, frame_err, prev_valid, prev_err);
         end
         if (frame_err) begin
            err_cnt++;
            err_cyc = cyc;
         end
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse got valid=%0b err=%0b code=%h required no pulse", code_valid, frame_err, code);
         end else begin
            e = sb.pop_front();
            if (frame_err != e.is_err ||
                (!e.is_err && (code !== e.code || code_ext !== e.ext || code_break !== e.brk))) begin
               errors++;
               $display("FAIL scoreboard got err=%0b code=%h ext=%0b brk=%0b required err=%0b code=%h ext=%0b brk=%0b",
                        frame_err, code, code_ext, code_break, e.is_err, e.code, e.ext, e.brk);
            end else begin
               $display("pulse err=%0b code=%h ext=%0b brk=%0b ok", frame_err, code, code_ext, code_break);
            end
         end
      end
      prev_valid <= code_valid;
      prev_err   <= frame_err;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // One PS/2 bit cell: data set during clock high, then a falling and rising clock.
   task automatic drive_bit(input logic b, input bit stay_low, input bit glitch);
      ps2_data = b;
      wait_cyc(HALF);
      ps2_clock = 1'b0;
      fall_cyc  = cyc;
      wait_cyc(HALF);
      if (!stay_low) begin
         ps2_clock = 1'b1;
         if (glitch) begin
            wait_cyc(8);
            ps2_clock = 1'b0;
            wait_cyc(3);
            ps2_clock = 1'b1;
            wait_cyc(HALF - 11);
         end else begin
            wait_cyc(HALF);
         end
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input bit flip_par, input bit bad_stop, input int glitch_at);
      $display("frame %h flip_par=%0b bad_stop=%0b glitch_at=%0d", d, flip_par, bad_stop, glitch_at);
      drive_bit(1'b0, 1'b0, glitch_at == 0);
      for (int i = 0; i < 8; i++) drive_bit(d[i], 1'b0, glitch_at == i + 1);
      drive_bit((~^d) ^ flip_par, 1'b0, 1'b0);
      drive_bit(!bad_stop, 1'b0, 1'b0);
      ps2_data = 1'b1;
      wait_cyc(2 * HALF);
   endtask

   function automatic exp_t mk_exp(input bit is_err, input logic [7:0] c, input bit ext, input bit brk);
      exp_t e;
      e.is_err = is_err;
      e.code   = c;
      e.ext    = ext;
      e.brk    = brk;
      return e;
   endfunction

   initial begin
      int e0;
      vecs[0]  = '{8'h1C, 1'b0, 1'b0, K_VALID,  8'h1C, 1'b0, 1'b0};
      vecs[1]  = '{8'hF0, 1'b0, 1'b0, K_PREFIX, 8'h00, 1'b0, 1'b0};
      vecs[2]  = '{8'h1C, 1'b0, 1'b0, K_VALID,  8'h1C, 1'b0, 1'b1};
      vecs[3]  = '{8'hE0, 1'b0, 1'b0, K_PREFIX, 8'h00, 1'b0, 1'b0};
      vecs[4]  = '{8'hF0, 1'b0, 1'b0, K_PREFIX, 8'h00, 1'b0, 1'b0};
      vecs[5]  = '{8'h75, 1'b0, 1'b0, K_VALID,  8'h75, 1'b1, 1'b1};
      vecs[6]  = '{8'h1C, 1'b1, 1'b0, K_ERR,    8'h00, 1'b0, 1'b0};
      vecs[7]  = '{8'hF0, 1'b0, 1'b0, K_PREFIX, 8'h00, 1'b0, 1'b0};
      vecs[8]  = '{8'h5A, 1'b0, 1'b1, K_ERR,    8'h00, 1'b0, 1'b0};
      vecs[9]  = '{8'h29, 1'b0, 1'b0, K_VALID,  8'h29, 1'b0, 1'b0};
      vecs[10] = '{8'h00, 1'b0, 1'b0, K_VALID,  8'h00, 1'b0, 1'b0};
      vecs[11] = '{8'hE0, 1'b0, 1'b0, K_PREFIX, 8'h00, 1'b0, 1'b0};
      vecs[12] = '{8'hFF, 1'b0, 1'b0, K_VALID,  8'hFF, 1'b1, 1'b0};

      wait_cyc(3);
      check("reset_code", 32'(code), 32'h0);
      check("reset_ext", 32'(code_ext), 32'h0);
      check("reset_brk", 32'(code_break), 32'h0);
      check("reset_valid", 32'(code_valid), 32'h0);
      check("reset_err", 32'(frame_err), 32'h0);
      check("reset_busy", 32'(busy), 32'h0);
      reset = 1'b0;
      wait_cyc(2 * HALF);

      for (int i = 0; i < 13; i++) begin
         case (vecs[i].kind)
            K_VALID:  sb.push_back(mk_exp(1'b0, vecs[i].code, vecs[i].ext & DEC, vecs[i].brk & DEC));
            K_PREFIX: if (!DEC) sb.push_back(mk_exp(1'b0, vecs[i].data, 1'b0, 1'b0));
            default:  sb.push_back(mk_exp(1'b1, 8'h00, 1'b0, 1'b0));
         endcase
         send_frame(vecs[i].data, vecs[i].flip_par, vecs[i].bad_stop, -1);
      end
      wait_cyc(50);
      check("code_held", 32'(code), 32'hFF);
      check("busy_idle", 32'(busy), 32'h0);

      // Start bit of 1 seen in IDLE.
      $display("frame bad_start");
      sb.push_back(mk_exp(1'b1, 8'h00, 1'b0, 1'b0));
      drive_bit(1'b1, 1'b0, 1'b0);
      wait_cyc(HALF);

      // Stall after five data bits with the clock stuck low.
      $display("frame stall_after_5_bits");
      sb.push_back(mk_exp(1'b1, 8'h00, 1'b0, 1'b0));
      e0 = err_cnt;
      drive_bit(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b0, 1'b0);
      drive_bit(1'b1, 1'b1, 1'b0);
      check("busy_mid_frame", 32'(busy), 32'h1);
      for (int i = 0; i < TO + 200 && err_cnt == e0; i++) @(posedge clock);
      #1;
      check("timeout_seen", 32'(err_cnt - e0), 32'h1);
      // Pin fall reaches the FSM 2 sync + FL filter + 1 edge-register cycles later.
      check("timeout_latency", err_cyc - fall_cyc, 32'(TO + FL + 3));
      check("busy_after_timeout", 32'(busy), 32'h0);
      ps2_clock = 1'b1;
      ps2_data  = 1'b1;
      wait_cyc(2 * HALF);
      sb.push_back(mk_exp(1'b0, 8'h1C, 1'b0, 1'b0));
      send_frame(8'h1C, 1'b0, 1'b0, -1);

      // Short clock glitch mid-frame is filtered out.
      sb.push_back(mk_exp(1'b0, 8'h75, 1'b0, 1'b0));
      send_frame(8'h75, 1'b0, 1'b0, 4);

      // Reset in the middle of a frame discards it silently.
      $display("frame reset_mid_frame");
      drive_bit(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) drive_bit(1'b1, 1'b0, 1'b0);
      reset = 1'b1;
      wait_cyc(1);
      check("midreset_code", 32'(code), 32'h0);
      check("midreset_valid", 32'(code_valid), 32'h0);
      check("midreset_err", 32'(frame_err), 32'h0);
      check("midreset_busy", 32'(busy), 32'h0);
      reset    = 1'b0;
      ps2_data = 1'b1;
      wait_cyc(2 * HALF);
      sb.push_back(mk_exp(1'b0, 8'h1C, 1'b0, 1'b0));
      send_frame(8'h1C, 1'b0, 1'b0, -1);
      check("post_reset_code", 32'(code), 32'h1C);

      wait_cyc(50);
      check("scoreboard_drained", 32'(sb.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got no finish required finish before time limit");
      $fatal(1, "watchdog");
   end

endmodule
